serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//  Parallel-to-serial frame transmitter: accepts a DATA_W-bit word via valid/ready, emits it
//  LSB-first on a single line framed by one start bit (0) and one stop bit (1).
//  Transmit end of the block-level serial link; the matching receiver samples tx_line.
//  All outputs are registered; single clock domain.
// PARAMETERS
//  DATA_W        8   payload bits per frame (1..16)
//  CLKS_PER_BIT  4   clock cycles each line bit is held (>=1)
// PORTS
//  clock     in   1        rising-edge clock
//  reset     in   1        asynchronous, active-high reset
//  tx_data   in   DATA_W   payload word, sampled on accept
//  tx_valid  in   1        producer has a word
//  tx_ready  out  1        transmitter can accept a word this cycle
//  tx_line   out  1        serial line, idles high
//  busy      out  1        frame in progress
//  done      out  1        one-cycle pulse after the last stop-bit cycle
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, tx_line=1, tx_ready=1, busy=0, done=0; counters=0.
//  Accept: tx_valid & tx_ready at a rising edge -> tx_data latched into shift register.
//   Next cycle: state=START, tx_line=0, tx_ready=0, busy=1.
//  FSM (each bit state lasts exactly CLKS_PER_BIT cycles, tracked by bit-timer):
//   IDLE  -> START on accept.
//   START -> DATA when bit-timer reaches CLKS_PER_BIT-1.
//   DATA  -> tx_line = shift[0]; shift right at end of each bit; after DATA_W bits -> STOP.
//   STOP  -> tx_line=1 for CLKS_PER_BIT cycles -> IDLE; done=1 for the first IDLE cycle.
//  Frame length: (DATA_W+2)*CLKS_PER_BIT cycles from first START cycle to first IDLE cycle.
//  tx_ready=1 only in IDLE (including the cycle done=1); back-to-back accept in that
//   cycle starts the next START immediately -> no idle gap between frames.
//  tx_valid while busy: ignored, tx_data not sampled; producer holds it until tx_ready.
//  tx_data changes after accept: no effect on the frame in flight.
//  CLKS_PER_BIT=1: one cycle per bit; bit-timer is constant 0.
//  Reset mid-frame: frame aborted, line returns high in the same cycle reset asserts;
//   no done pulse; next frame starts cleanly after reset deasserts.
//  Bit counter width: $clog2(DATA_W+1); bit-timer width: $clog2(CLKS_PER_BIT+1).
// CONFIGURATION
//  PARITY_TX_EN defined: a PARITY state is inserted between DATA and STOP, driving
//   even parity (^payload) for CLKS_PER_BIT cycles; frame = (DATA_W+3)*CLKS_PER_BIT cycles.
//  PARITY_TX_EN undefined: no PARITY state, frame = (DATA_W+2)*CLKS_PER_BIT cycles;
//   the state encoding need not reserve the parity code.
// TESTING
//  1. Reset asserted mid-cycle -> tx_line=1, tx_ready=1, busy=0, done=0 without a clock edge.
//  2. Defaults, send 8'hA5 -> line: 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; done one cycle
//     after 40 busy cycles.
//  3. Back-to-back 8'h00 then 8'hFF with tx_valid held -> second start bit follows first
//     stop bit with zero idle cycles; tx_ready high for exactly one cycle between frames.
//  4. tx_valid pulsed with 8'h3C while busy -> ignored; in-flight frame unchanged, no second frame.
//  5. Reset asserted during data bit 3 of 8'hFF -> line=1 at once, no done; new
//     8'h81 sent after release frames correctly.
//  6. PARITY_TX_EN, send 8'h07 -> parity bit 1 between bit7 and stop, 44-cycle frame;
//     8'h03 -> parity bit 0.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Accepts a DATA_W-bit word over valid/ready and sends it LSB-first on tx_line.
// Each frame is one start bit (0), DATA_W payload bits and one stop bit (1).
// Every line bit is held for CLKS_PER_BIT clocks. All outputs are registered.
// Optional build macro PARITY_TX_EN: when it is defined, an even-parity bit
// (^payload) is sent between the last data bit and the stop bit.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy,
  output logic              done
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

`ifdef PARITY_TX_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state;
  logic [TW-1:0]     bit_tmr;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nx;
  logic              accept;
  logic              bit_end;

  assign accept   = tx_valid & tx_ready;
  // With CLKS_PER_BIT=1 the timer never leaves 0, so every cycle ends a bit.
  assign bit_end  = (bit_tmr == T_LAST);
  // Next payload bit to put on the line once the current data bit ends.
  assign shift_nx = shift >> 1;

  // Payload register: loads only on accept, so tx_data changes mid-frame have no effect.
  always_ff @(posedge clock) begin
    if (accept) begin
      shift <= tx_data;
    end else if ((state == S_DATA) && bit_end) begin
      shift <= shift_nx;
    end
  end

`ifdef PARITY_TX_EN
  logic parity_bit;

  // Parity is captured from the accepted word, before any shifting.
  always_ff @(posedge clock) begin
    if (accept) begin
      parity_bit <= ^tx_data;
    end
  end
`endif

  // Frame sequencer: drives the line, handshake and status outputs directly as registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tx_line  <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_tmr  <= '0;
      bit_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_START;
            tx_line  <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            bit_tmr  <= '0;
            bit_cnt  <= '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            tx_line <= shift[0];
            bit_tmr <= '0;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_tmr <= '0;
            if (bit_cnt == B_LAST) begin
`ifdef PARITY_TX_EN
              state   <= S_PARITY;
              tx_line <= parity_bit;
`else
              state   <= S_STOP;
              tx_line <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_line <= shift_nx[0];
            end
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
`ifdef PARITY_TX_EN
        S_PARITY: begin
          if (bit_end) begin
            state   <= S_STOP;
            tx_line <= 1'b1;
            bit_tmr <= '0;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            // Returning to IDLE re-opens the handshake in the same cycle done pulses,
            // which lets a waiting producer start the next frame with no idle gap.
            state    <= S_IDLE;
            tx_line  <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            bit_tmr  <= '0;
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          tx_line  <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          bit_tmr  <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx: randomized frames checked by a scoreboard.
// A stimulus process pushes each accepted word; a monitor process rebuilds the
// expected line waveform from the word and compares it cycle by cycle.
module tb_serial_frame_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef PARITY_TX_EN
  localparam int NBITS  = DATA_W + 3;
`else
  localparam int NBITS  = DATA_W + 2;
`endif
  localparam int FL     = NBITS * CPB;

  logic              clock;
  logic              reset;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_line;
  logic              busy;
  logic              done;

  int vectors;
  int miscompares;
  logic [DATA_W-1:0] exp_q[$];

  serial_frame_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_line (tx_line),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Line level for frame bit number idx: start, payload LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [DATA_W-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DATA_W) return w[idx-1];
`ifdef PARITY_TX_EN
    if (idx == DATA_W + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic run_monitor();
    logic [DATA_W-1:0] cur;
    int pos;
    bit active;
    bit exp_done;
    cur = '0; pos = 0; active = 0; exp_done = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        active   = 0;
        exp_done = 0;
      end else if (active) begin
        check("frame_line", tx_line, exp_bit(cur, pos / CPB));
        check("frame_busy", busy, 1);
        pos++;
        if (pos == FL) begin
          active   = 0;
          exp_done = 1;
        end
      end else if (exp_done) begin
        check("done_pulse", done, 1);
        check("done_ready", tx_ready, 1);
        check("done_busy", busy, 0);
        check("done_line", tx_line, 1);
        exp_done = 0;
      end else if (busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", busy, 0);
        end else begin
          cur = exp_q.pop_front();
          check("start_bit", tx_line, 0);
          check("start_ready", tx_ready, 0);
          pos    = 1;
          active = 1;
        end
      end else begin
        check("idle_line", tx_line, 1);
        check("idle_done", done, 0);
        check("idle_ready", tx_ready, 1);
      end
    end
  endtask

  // Offer a word; it is recorded as expected only at the edge that accepts it.
  task automatic send(input logic [DATA_W-1:0] w, input bit hold);
    int n;
    @(negedge clock);
    tx_data  = w;
    tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 3 * FL) begin
      @(negedge clock);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      check("accept_timeout", tx_ready, 1);
      tx_valid = 1'b0;
      return;
    end
    exp_q.push_back(w);
    @(posedge clock);
    #1;
    if (!hold) tx_valid = 1'b0;
    tx_data = DATA_W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3 * FL) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", busy, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic async_reset_check();
    #2 reset = 1'b1;
    #1;
    check("rst_line", tx_line, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    fork
      run_monitor();
    join_none

    // Reset applied mid-cycle, before any clock edge.
    async_reset_check();

    // Single frame of 8'hA5.
    send(8'hA5, 1'b0);
    wait_idle();

    // Back-to-back frames with tx_valid held across the boundary.
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    check("b2b_ready_one_cycle", tx_ready, 0);
    check("b2b_busy", busy, 1);
    wait_idle();

    // A valid pulse while busy must be ignored.
    send(8'hC3, 1'b0);
    repeat (3 * CPB) @(negedge clock);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    wait_idle();
    repeat (FL) @(negedge clock);

    // Reset during data bit 3 of 8'hFF, then a clean frame afterwards.
    send(8'hFF, 1'b0);
    repeat (4 * CPB + 2) @(negedge clock);
    check("pre_reset_busy", busy, 1);
    async_reset_check();
    send(8'h81, 1'b0);
    wait_idle();

    // Parity-sensitive payloads.
    send(8'h07, 1'b0);
    send(8'h03, 1'b0);
    wait_idle();

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      bit hold;
      hold = 1'($urandom_range(0, 1));
      send(DATA_W'($urandom), hold);
      if (!hold) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, FL - 8)) @(negedge clock);
          tx_data  = DATA_W'($urandom);
          tx_valid = 1'b1;
          @(negedge clock);
          tx_valid = 1'b0;
        end else begin
          repeat ($urandom_range(0, 2 * CPB)) @(negedge clock);
        end
      end
    end
    tx_valid = 1'b0;
    wait_idle();
    repeat (4) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
